// File: rtl/mux4_rr_arbiter.sv
// mux4_rr_arbiter
//   Round-robin arbiter sharing one N-bit registered result path between four
//   requesters (A=0, B=1, C=2, D=3). The winner's operand is captured into y,
//   and its index is presented as the {s1,s0} select encoding of the 4-input mux.
//   The output register uses a valid/ready handshake. Back-to-back captures give
//   one operand per clock.
//
// Ports
//   clk      in   rising-edge clock
//   rst_n    in   asynchronous active-low reset
//   req      in   [3:0] request level per source, held until acked
//   A,B,C,D  in   [N-1:0] source operands
//   ack      out  [3:0] one-hot, one-cycle pulse: that source was captured
//   s1,s0    out  registered select of the current grant
//   y        out  [N-1:0] registered selected operand
//   y_valid  out  y holds an unconsumed operand
//   y_ready  in   downstream accepts y when high with y_valid
//   busy     out  high while holding an operand
module mux4_rr_arbiter #(
  parameter int N = 4
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic [3:0]   req,
  input  logic [N-1:0] A,
  input  logic [N-1:0] B,
  input  logic [N-1:0] C,
  input  logic [N-1:0] D,
  output logic [3:0]   ack,
  output logic         s1,
  output logic         s0,
  output logic [N-1:0] y,
  output logic         y_valid,
  input  logic         y_ready,
  output logic         busy
);

  typedef enum logic {IDLE, HOLD} state_t;

  state_t       state_q, state_d;
  logic [1:0]   ptr_q, ptr_d;
  logic [1:0]   sel_q, sel_d;
  logic [N-1:0] y_q, y_d;
  logic [3:0]   ack_q, ack_d;

  logic [3:0]   elig;
  logic [1:0]   grant;
  logic [1:0]   idx;
  logic         any_elig;
  logic         capture;
  logic [N-1:0] operand;

  // A source acked this cycle is masked so a requester that drops req one
  // cycle late is never granted twice.
  assign elig = req & ~ack_q;

  // Search upward from ptr, wrapping 3->0; first eligible index wins.
  always_comb begin
    grant    = '0;
    any_elig = 1'b0;
    idx      = '0;
    for (int unsigned i = 0; i < 4; i++) begin
      idx = ptr_q + 2'(i);
      if (!any_elig && elig[idx]) begin
        grant    = idx;
        any_elig = 1'b1;
      end
    end
  end

  always_comb begin
    case (grant)
      2'd0:    operand = A;
      2'd1:    operand = B;
      2'd2:    operand = C;
      default: operand = D;
    endcase
  end

  always_comb begin
    state_d = state_q;
    capture = 1'b0;
    case (state_q)
      IDLE: begin
        if (any_elig) begin
          capture = 1'b1;
          state_d = HOLD;
        end
      end
      HOLD: begin
        // Only a transfer edge frees the register; a new capture on the same
        // edge keeps the pipe full.
        if (y_ready) begin
          if (any_elig) capture = 1'b1;
          else          state_d = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase

    y_d   = capture ? operand : y_q;
    sel_d = capture ? grant : sel_q;
    ptr_d = capture ? grant + 2'd1 : ptr_q;
    ack_d = capture ? (4'b0001 << grant) : '0;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= IDLE;
      ptr_q   <= '0;
      sel_q   <= '0;
      y_q     <= '0;
      ack_q   <= '0;
    end else begin
      state_q <= state_d;
      ptr_q   <= ptr_d;
      sel_q   <= sel_d;
      y_q     <= y_d;
      ack_q   <= ack_d;
    end
  end

  assign y       = y_q;
  assign s1      = sel_q[1];
  assign s0      = sel_q[0];
  assign ack     = ack_q;
  assign y_valid = (state_q == HOLD);
  assign busy    = (state_q == HOLD);

endmodule

// File: tb/tb_mux4_rr_arbiter.sv
// Directed testbench for mux4_rr_arbiter (N=4).
// Observed vector layout: {y[3:0], s1, s0, ack[3:0], y_valid, busy}.
module tb_mux4_rr_arbiter;

  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic [3:0] req = '0;
  logic [3:0] A = '0, B = '0, C = '0, D = '0;
  logic [3:0] ack;
  logic       s1, s0;
  logic [3:0] y;
  logic       y_valid;
  logic       y_ready = 1'b1;
  logic       busy;

  logic [11:0] obs;
  int pass_cnt = 0;
  int total    = 0;

  assign obs = {y, s1, s0, ack, y_valid, busy};

  always #5 clk = ~clk;

  mux4_rr_arbiter #(.N(4)) dut (
    .clk(clk), .rst_n(rst_n), .req(req),
    .A(A), .B(B), .C(C), .D(D),
    .ack(ack), .s1(s1), .s0(s0), .y(y),
    .y_valid(y_valid), .y_ready(y_ready), .busy(busy)
  );

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    req = '0; y_ready = 1'b1;
    rst_n = 1'b0;
    tick();
    rst_n = 1'b1;
  endtask

  task automatic test_reset();
    #1;
    total++;
    if (obs !== 12'b0000_00_0000_0_0) $display("FAIL reset_asserted: got %b want %b", obs, 12'b0);
    else pass_cnt++;
    tick();
    rst_n = 1'b1;
    for (int i = 0; i < 5; i++) begin
      tick();
      total++;
      if (obs !== 12'b0000_00_0000_0_0) $display("FAIL idle_%0d: got %b want %b", i, obs, 12'b0);
      else pass_cnt++;
    end
  endtask

  task automatic test_single();
    C = 4'hA; y_ready = 1'b1; req = 4'b0100;
    tick();
    total++;
    if (obs !== {4'hA, 2'b10, 4'b0100, 1'b1, 1'b1})
      $display("FAIL single_cap: got %b want %b", obs, {4'hA, 2'b10, 4'b0100, 1'b1, 1'b1});
    else pass_cnt++;
    req = '0;
    tick();
    total++;
    if (obs !== {4'hA, 2'b10, 4'b0000, 1'b0, 1'b0})
      $display("FAIL single_drain: got %b want %b", obs, {4'hA, 2'b10, 4'b0000, 1'b0, 1'b0});
    else pass_cnt++;
  endtask

  // Follows test_single, so ptr=3: D wins first, then the pointer wraps to A
  // while D's still-high req is masked by its ack.
  task automatic test_wrap_mask();
    A = 4'h1; D = 4'hD; req = 4'b1001;
    tick();
    total++;
    if (obs !== {4'hD, 2'b11, 4'b1000, 1'b1, 1'b1})
      $display("FAIL wrap_d: got %b want %b", obs, {4'hD, 2'b11, 4'b1000, 1'b1, 1'b1});
    else pass_cnt++;
    tick();
    total++;
    if (obs !== {4'h1, 2'b00, 4'b0001, 1'b1, 1'b1})
      $display("FAIL wrap_a_mask: got %b want %b", obs, {4'h1, 2'b00, 4'b0001, 1'b1, 1'b1});
    else pass_cnt++;
    req = '0;
    tick();
    total++;
    if (obs !== {4'h1, 2'b00, 4'b0000, 1'b0, 1'b0})
      $display("FAIL wrap_drain: got %b want %b", obs, {4'h1, 2'b00, 4'b0000, 1'b0, 1'b0});
    else pass_cnt++;
  endtask

  task automatic test_round_robin();
    logic [3:0] exp_y   [5] = '{4'd1, 4'd2, 4'd3, 4'd4, 4'd1};
    logic [1:0] exp_sel [5] = '{2'd0, 2'd1, 2'd2, 2'd3, 2'd0};
    logic [3:0] exp_ack [5] = '{4'b0001, 4'b0010, 4'b0100, 4'b1000, 4'b0001};
    do_reset();
    A = 4'd1; B = 4'd2; C = 4'd3; D = 4'd4;
    req = 4'b1111; y_ready = 1'b1;
    for (int i = 0; i < 5; i++) begin
      tick();
      total++;
      if (obs !== {exp_y[i], exp_sel[i], exp_ack[i], 1'b1, 1'b1})
        $display("FAIL rr_%0d: got %b want %b", i, obs, {exp_y[i], exp_sel[i], exp_ack[i], 1'b1, 1'b1});
      else pass_cnt++;
    end
    req = '0;
    tick();
    total++;
    if (obs !== {4'd1, 2'b00, 4'b0000, 1'b0, 1'b0})
      $display("FAIL rr_drain: got %b want %b", obs, {4'd1, 2'b00, 4'b0000, 1'b0, 1'b0});
    else pass_cnt++;
  endtask

  task automatic test_backpressure();
    do_reset();
    A = 4'h5; B = 4'h6; req = 4'b0011; y_ready = 1'b0;
    tick();
    total++;
    if (obs !== {4'h5, 2'b00, 4'b0001, 1'b1, 1'b1})
      $display("FAIL bp_cap: got %b want %b", obs, {4'h5, 2'b00, 4'b0001, 1'b1, 1'b1});
    else pass_cnt++;
    req = 4'b0010;
    for (int i = 0; i < 4; i++) begin
      tick();
      total++;
      if (obs !== {4'h5, 2'b00, 4'b0000, 1'b1, 1'b1})
        $display("FAIL bp_hold_%0d: got %b want %b", i, obs, {4'h5, 2'b00, 4'b0000, 1'b1, 1'b1});
      else pass_cnt++;
    end
    y_ready = 1'b1;
    tick();
    total++;
    if (obs !== {4'h6, 2'b01, 4'b0010, 1'b1, 1'b1})
      $display("FAIL bp_release: got %b want %b", obs, {4'h6, 2'b01, 4'b0010, 1'b1, 1'b1});
    else pass_cnt++;
    req = '0;
    tick();
    total++;
    if (obs !== {4'h6, 2'b01, 4'b0000, 1'b0, 1'b0})
      $display("FAIL bp_drain: got %b want %b", obs, {4'h6, 2'b01, 4'b0000, 1'b0, 1'b0});
    else pass_cnt++;
  endtask

  task automatic test_midreset();
    do_reset();
    C = 4'h7; req = 4'b0100; y_ready = 1'b0;
    tick();
    total++;
    if (obs !== {4'h7, 2'b10, 4'b0100, 1'b1, 1'b1})
      $display("FAIL mr_cap: got %b want %b", obs, {4'h7, 2'b10, 4'b0100, 1'b1, 1'b1});
    else pass_cnt++;
    req = '0;
    #2 rst_n = 1'b0;
    #1;
    total++;
    if (obs !== 12'b0)
      $display("FAIL mr_async_clear: got %b want %b", obs, 12'b0);
    else pass_cnt++;
    B = 4'h9; req = 4'b0010;
    #1 rst_n = 1'b1;
    tick();
    total++;
    if (obs !== {4'h9, 2'b01, 4'b0010, 1'b1, 1'b1})
      $display("FAIL mr_first_cap: got %b want %b", obs, {4'h9, 2'b01, 4'b0010, 1'b1, 1'b1});
    else pass_cnt++;
  endtask

  initial begin
    test_reset();
    test_single();
    test_wrap_mask();
    test_round_robin();
    test_backpressure();
    test_midreset();
    $display("%0d/%0d checks passed", pass_cnt, total);
    $finish;
  end

endmodule
